// File: rtl/iex_branch_resolver_pkg.sv
// Shared definitions for the IEX branch resolver.
//   - `DATA_WIDTH : default datapath / PC width (XLEN source), overridable
//   - funct3 encodings of the conditional branches
//   - 2-bit resolver FSM state encoding
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package iex_branch_resolver_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_t;

endpackage

// File: rtl/iex_branch_resolver_cond_eval.sv
// br_cond_eval: combinational branch condition evaluation.
// Ports:
//   funct3  in   3     branch encoding (undefined encodings resolve not taken)
//   rs1     in   XLEN  first operand
//   rs2     in   XLEN  second operand
//   taken   out  1     condition holds
module br_cond_eval
    import iex_branch_resolver_pkg::*;
#(
    parameter int XLEN = `DATA_WIDTH
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/iex_branch_resolver.sv
// iex_branch_resolver: resolves branches/jumps in IEX, redirects IF over a
// valid/ready handshake, holds a flush for FLUSH_CYCLES after the redirect is
// accepted, and returns the JAL/JALR link value (pc+4).
// Optional feature macro: BRANCH_PERF_CNT_EN adds br_cnt_o / taken_cnt_o.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   br_valid_i / br_ready_o       op handshake (ready only in IDLE)
//   br_funct3_i, br_is_jal_i, br_is_jalr_i, br_pc_i, br_imm_i, br_rs1_i, br_rs2_i
//   redir_valid_o / redir_ready_i, redir_pc_o   redirect to IF
//   flush_o                       kill younger ops (REDIRECT and FLUSH)
//   link_valid_o, link_data_o     1-cycle link writeback pulse, pc+4
//   misalign_o                    1-cycle pulse, taken target has bit[1] set
//   br_cnt_o, taken_cnt_o         conditional branch perf counters (macro only)
module iex_branch_resolver
    import iex_branch_resolver_pkg::*;
#(
    parameter int XLEN         = `DATA_WIDTH,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid_i,
    output logic                 br_ready_o,
    input  logic [2:0]           br_funct3_i,
    input  logic                 br_is_jal_i,
    input  logic                 br_is_jalr_i,
    input  logic [XLEN-1:0]      br_pc_i,
    input  logic [XLEN-1:0]      br_imm_i,
    input  logic [XLEN-1:0]      br_rs1_i,
    input  logic [XLEN-1:0]      br_rs2_i,
    output logic                 redir_valid_o,
    input  logic                 redir_ready_i,
    output logic [XLEN-1:0]      redir_pc_o,
    output logic                 flush_o,
    output logic                 link_valid_o,
    output logic [XLEN-1:0]      link_data_o,
    output logic                 misalign_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] br_cnt_o,
    output logic [CNT_WIDTH-1:0] taken_cnt_o
`endif
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    br_state_t       state;
    br_state_t       state_next;
    logic [FCW-1:0]  flush_cnt;
    logic            ready_q;

    logic            cond_taken;
    logic            is_jump;
    logic            taken;
    logic            accept;
    logic [XLEN-1:0] target_base;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic            go_redirect;

    br_cond_eval #(
        .XLEN (XLEN)
    ) u_cond_eval (
        .funct3 (br_funct3_i),
        .rs1    (br_rs1_i),
        .rs2    (br_rs2_i),
        .taken  (cond_taken)
    );

    assign is_jump     = br_is_jal_i | br_is_jalr_i;
    assign taken       = is_jump | cond_taken;
    assign accept      = br_valid_i & ready_q;
    assign target_base = br_is_jalr_i ? br_rs1_i : br_pc_i;
    assign target_sum  = target_base + br_imm_i;
    assign target      = {target_sum[XLEN-1:1], target_sum[0] & ~br_is_jalr_i};
    assign go_redirect = accept & taken & ~target[1];

    // ready is registered so it stays low for the whole reset and first rises
    // on the edge after reset is released.
    assign br_ready_o = ready_q;

    always_comb begin
        state_next    = state;
        redir_valid_o = 1'b0;
        flush_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go_redirect) state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redir_valid_o = 1'b1;
                flush_o       = 1'b1;
                if (redir_ready_i) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
                if (flush_cnt == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b0;
            flush_cnt    <= '0;
            redir_pc_o   <= '0;
            link_valid_o <= 1'b0;
            link_data_o  <= '0;
            misalign_o   <= 1'b0;
        end else begin
            state        <= state_next;
            ready_q      <= (state_next == ST_IDLE);
            link_valid_o <= accept & is_jump;
            misalign_o   <= accept & taken & target[1];
            if (accept & is_jump) link_data_o <= br_pc_i + XLEN'(4);
            if (go_redirect)      redir_pc_o  <= target;
            if (state == ST_REDIRECT)
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
            else if (state == ST_FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - FCW'(1);
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_o    <= '0;
            taken_cnt_o <= '0;
        end else if (accept & ~is_jump) begin
            br_cnt_o <= br_cnt_o + CNT_WIDTH'(1);
            if (cond_taken) taken_cnt_o <= taken_cnt_o + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
